// File: rtl/issueq_pkg.sv
// Shared constants and types for the issue-queue free list.
package issueq_pkg;

  localparam int IQ_DEPTH   = 32;
  localparam int IQ_IDX_W   = $clog2(IQ_DEPTH);
  localparam int IQ_CNT_W   = $clog2(IQ_DEPTH + 1);
  localparam int DISPATCH_W = 4;
  localparam int ISSUE_W    = 4;

  typedef logic [IQ_IDX_W-1:0] iq_idx_t;

endpackage

// File: rtl/issueq_fl_pack.sv
// Sparse-valid compaction helper: for every lane, the number of set valid bits
// strictly below it (its slot in the compacted order), plus the total popcount.
module issueq_fl_pack #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         valid,
  output logic [W-1:0][CW-1:0] rank,
  output logic [CW-1:0]        count
);

  // Each rank is a separate sum over the lanes below it, so no signal feeds back into itself.
  function automatic logic [CW-1:0] popBelow(input logic [W-1:0] v, input int n);
    logic [CW-1:0] acc;
    acc = '0;
    for (int j = 0; j < W; j++) begin
      if (j < n) acc = acc + CW'(v[j]);
    end
    return acc;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rank
      assign rank[gi] = popBelow(valid, gi);
    end
  endgenerate

  assign count = popBelow(valid, W);

endmodule

// File: rtl/issueq_freelist_mw.sv
// Multi-way issue-queue free list: circular FIFO of free entry indices.
// Dispatch pops up to ALLOC_W entries per cycle (all-or-nothing), issue pushes
// up to FREE_W freed entries per cycle. Optional flush port is enabled by
// defining ISSUEQ_FL_FLUSH_EN; without it the list recovers only via frees.
module issueq_freelist_mw
  import issueq_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int ALLOC_W = DISPATCH_W,
  parameter int FREE_W  = ISSUE_W,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ALLOC_W-1:0]        allocReq_i,
  output logic                      allocReady_o,
  output logic [ALLOC_W*IDX_W-1:0]  allocIdx_o,
  input  logic [FREE_W-1:0]         freeValid_i,
  input  logic [FREE_W*IDX_W-1:0]   freeIdx_i,
  output logic [CNT_W-1:0]          freeCnt_o,
  output logic [CNT_W-1:0]          usedCnt_o
`ifdef ISSUEQ_FL_FLUSH_EN
  ,
  input  logic                      flush_i
`endif
);

  localparam int ARW = $clog2(ALLOC_W + 1);
  localparam int FRW = $clog2(FREE_W + 1);

  logic [IDX_W-1:0]              listReg [DEPTH];
  logic [IDX_W-1:0]              headReg;
  logic [IDX_W-1:0]              tailReg;
  logic [CNT_W-1:0]              freeCntReg;
  logic [CNT_W:0]                freeCntWide;
  logic                          flushActive;
  logic                          allocFire;
  logic [ALLOC_W-1:0][ARW-1:0]   allocRank;
  logic [ARW-1:0]                allocPop;
  logic [FREE_W-1:0][FRW-1:0]    freeRank;
  logic [FRW-1:0]                freePop;
  logic [FREE_W-1:0][IDX_W-1:0]  freeAddr;

  // Pointer add with a single conditional subtract; offsets never exceed DEPTH,
  // so this wraps correctly for non-power-of-two depths.
  function automatic logic [IDX_W-1:0] modAdd(input logic [IDX_W-1:0] base, input logic [31:0] off);
    logic [31:0] sum;
    sum = 32'(base) + off;
    if (sum >= 32'(DEPTH)) sum = sum - 32'(DEPTH);
    return IDX_W'(sum);
  endfunction

`ifdef ISSUEQ_FL_FLUSH_EN
  assign flushActive = flush_i;
`else
  assign flushActive = 1'b0;
`endif

  issueq_fl_pack #(.W(ALLOC_W), .CW(ARW)) allocPack (
    .valid (allocReq_i),
    .rank  (allocRank),
    .count (allocPop)
  );

  issueq_fl_pack #(.W(FREE_W), .CW(FRW)) freePack (
    .valid (freeValid_i),
    .rank  (freeRank),
    .count (freePop)
  );

  // Readiness uses only the registered count: same-cycle frees are not bypassed.
  assign allocReady_o = ~flushActive & (32'(allocPop) <= 32'(freeCntReg));
  assign allocFire    = allocReady_o & (|allocReq_i);

  genvar gi;
  generate
    // Requesting lanes read consecutive list slots in lane order; idle lanes
    // show the slot at their own lane offset.
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
      assign allocIdx_o[gi*IDX_W +: IDX_W] =
        listReg[modAdd(headReg, allocReq_i[gi] ? 32'(allocRank[gi]) : 32'(gi))];
    end
    // Valid free lanes land at consecutive slots from the tail.
    for (gi = 0; gi < FREE_W; gi++) begin : g_free
      assign freeAddr[gi] = modAdd(tailReg, 32'(freeRank[gi]));
    end
  endgenerate

  // Next occupancy; carried one bit wider so a duplicate free is observable.
  always_comb begin
    freeCntWide = {1'b0, freeCntReg} + (CNT_W+1)'(freePop);
    if (allocFire) freeCntWide = freeCntWide - (CNT_W+1)'(allocPop);
  end

  // List storage: identity on reset/flush, otherwise write compacted frees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) listReg[i] <= IDX_W'(i);
    end else if (flushActive) begin
      for (int i = 0; i < DEPTH; i++) listReg[i] <= IDX_W'(i);
    end else begin
      for (int k = 0; k < FREE_W; k++) begin
        if (freeValid_i[k]) listReg[freeAddr[k]] <= freeIdx_i[k*IDX_W +: IDX_W];
      end
    end
  end

  // Head, tail and count registers; head and tail advance independently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      headReg    <= '0;
      tailReg    <= '0;
      freeCntReg <= CNT_W'(DEPTH);
    end else if (flushActive) begin
      headReg    <= '0;
      tailReg    <= '0;
      freeCntReg <= CNT_W'(DEPTH);
    end else begin
      if (allocFire) headReg <= modAdd(headReg, 32'(allocPop));
      tailReg    <= modAdd(tailReg, 32'(freePop));
      freeCntReg <= CNT_W'(freeCntWide);
    end
  end

  assign freeCnt_o = freeCntReg;
  assign usedCnt_o = CNT_W'(DEPTH) - freeCntReg;

  // A free count above DEPTH means an entry was freed twice.
  assert property (@(posedge clock) disable iff (!reset_n)
                   flushActive || (freeCntWide <= (CNT_W+1)'(DEPTH)));

endmodule

// File: tb/tb_issueq_freelist_mw.sv
// Directed + scoreboarded random bench for issueq_freelist_mw (default parameters).
module tb_issueq_freelist_mw;
  import issueq_pkg::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int AW    = DISPATCH_W;
  localparam int FW    = ISSUE_W;
  localparam int IW    = IQ_IDX_W;
  localparam int CW    = IQ_CNT_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     allocReq = '0;
  logic              allocReady;
  logic [AW*IW-1:0]  allocIdx;
  logic [FW-1:0]     freeValid = '0;
  logic [FW*IW-1:0]  freeIdx = '0;
  logic [CW-1:0]     freeCnt;
  logic [CW-1:0]     usedCnt;
`ifdef ISSUEQ_FL_FLUSH_EN
  logic              flush = 1'b0;
`endif

  int totalCnt = 0;
  int badCnt   = 0;
  int q[$];
  int used[$];
  int pend[$];

  always #5 clock = ~clock;

  issueq_freelist_mw dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .allocReq_i   (allocReq),
    .allocReady_o (allocReady),
    .allocIdx_o   (allocIdx),
    .freeValid_i  (freeValid),
    .freeIdx_i    (freeIdx),
    .freeCnt_o    (freeCnt),
    .usedCnt_o    (usedCnt)
`ifdef ISSUEQ_FL_FLUSH_EN
    ,
    .flush_i      (flush)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic iq_idx_t laneIdx(input int k);
    return allocIdx[k*IW +: IW];
  endfunction

  task automatic doReset();
    allocReq  = '0;
    freeValid = '0;
    freeIdx   = '0;
    reset_n   = 1'b0;
    #1;
    checkVal("rst_free", freeCnt, DEPTH);
    checkVal("rst_used", usedCnt, 0);
    checkVal("rst_ready", allocReady, 1);
    reset_n = 1'b1;
    $display("txn reset free=%0d used=%0d", freeCnt, usedCnt);
  endtask

  task automatic allocCycle(input logic [AW-1:0] req);
    allocReq = req;
    tick();
    allocReq = '0;
  endtask

  initial begin
    int n;
    int v;
    int j;
    int pa;
    int pf;
    logic expReady;

    #7;
    // 1: full-width allocation from reset
    doReset();
    allocReq = 4'b1111;
    settle();
    checkVal("t1_ready", allocReady, 1);
    for (int k = 0; k < AW; k++) checkVal("t1_idx", laneIdx(k), k);
    $display("txn t1 alloc req=%b idx=%0d,%0d,%0d,%0d", allocReq, laneIdx(0), laneIdx(1), laneIdx(2), laneIdx(3));
    tick();
    allocReq = '0;
    settle();
    checkVal("t1_free", freeCnt, 28);
    checkVal("t1_used", usedCnt, 4);

    // 2: sparse allocation after an asynchronous mid-operation reset
    doReset();
    allocReq = 4'b1010;
    settle();
    checkVal("t2_lane1", laneIdx(1), 0);
    checkVal("t2_lane3", laneIdx(3), 1);
    $display("txn t2 alloc req=%b lane1=%0d lane3=%0d", allocReq, laneIdx(1), laneIdx(3));
    tick();
    allocReq = 4'b0001;
    settle();
    checkVal("t2_free", freeCnt, 30);
    checkVal("t2_next", laneIdx(0), 2);
    allocReq = '0;

    // 3: sparse free pushed in lane order, returned after the list wraps
    doReset();
    for (int c = 0; c < 3; c++) allocCycle(4'b1111);
    freeValid = 4'b0101;
    freeIdx   = {5'd31, 5'd9, 5'd31, 5'd7};
    tick();
    freeValid = '0;
    settle();
    checkVal("t3_free", freeCnt, 22);
    $display("txn t3 free fv=0101 idx=7,9 free=%0d", freeCnt);
    for (int c = 0; c < 5; c++) begin
      allocReq = 4'b1111;
      settle();
      for (int k = 0; k < AW; k++) checkVal("t3_pop", laneIdx(k), 12 + 4*c + k);
      tick();
    end
    allocReq = 4'b0011;
    settle();
    checkVal("t3_ret0", laneIdx(0), 7);
    checkVal("t3_ret1", laneIdx(1), 9);
    $display("txn t3 alloc req=0011 idx=%0d,%0d", laneIdx(0), laneIdx(1));
    tick();
    allocReq = '0;
    settle();
    checkVal("t3_empty", freeCnt, 0);
    checkVal("t3_zero_rdy", allocReady, 1);
    allocReq = 4'b0001;
    settle();
    checkVal("t3_empty_rdy", allocReady, 0);
    allocReq = '0;

    // 4: insufficient entries, no bypass of same-cycle free
    freeValid = 4'b0111;
    freeIdx   = {5'd0, 5'd2, 5'd1, 5'd0};
    tick();
    freeValid = '0;
    settle();
    checkVal("t4_free3", freeCnt, 3);
    allocReq  = 4'b1111;
    freeValid = 4'b1000;
    freeIdx   = {5'd3, 5'd0, 5'd0, 5'd0};
    settle();
    checkVal("t4_notrdy", allocReady, 0);
    $display("txn t4 alloc req=1111 free=%0d ready=%0d", freeCnt, allocReady);
    tick();
    freeValid = '0;
    settle();
    checkVal("t4_free4", freeCnt, 4);
    checkVal("t4_rdy", allocReady, 1);
    for (int k = 0; k < AW; k++) checkVal("t4_idx", laneIdx(k), k);
    allocReq = '0;

`ifdef ISSUEQ_FL_FLUSH_EN
    // 6: flush with concurrent alloc/free restores the identity list
    doReset();
    for (int c = 0; c < 5; c++) allocCycle(4'b1111);
    allocCycle(4'b0011);
    settle();
    checkVal("t6_free10", freeCnt, 10);
    flush     = 1'b1;
    allocReq  = 4'b1111;
    freeValid = 4'b0001;
    freeIdx   = '0;
    settle();
    checkVal("t6_flush_rdy", allocReady, 0);
    tick();
    flush     = 1'b0;
    freeValid = '0;
    settle();
    checkVal("t6_free", freeCnt, DEPTH);
    checkVal("t6_rdy", allocReady, 1);
    for (int k = 0; k < AW; k++) checkVal("t6_idx", laneIdx(k), k);
    $display("txn t6 flush free=%0d idx=%0d,%0d,%0d,%0d", freeCnt, laneIdx(0), laneIdx(1), laneIdx(2), laneIdx(3));
    allocReq = '0;
`endif

    // 5: random sparse alloc/free against a FIFO scoreboard
    doReset();
    q.delete();
    used.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      pa = ((cyc / 100) % 2 == 0) ? 75 : 25;
      pf = ((cyc / 100) % 2 == 0) ? 25 : 70;
      pend.delete();
      freeValid = '0;
      freeIdx   = '0;
      for (int k = 0; k < FW; k++) begin
        if (used.size() > 0 && $urandom_range(99) < pf) begin
          j = $urandom_range(used.size() - 1);
          v = used[j];
          used.delete(j);
          freeValid[k] = 1'b1;
          freeIdx[k*IW +: IW] = IW'(v);
          pend.push_back(v);
        end
      end
      allocReq = '0;
      for (int k = 0; k < AW; k++) allocReq[k] = ($urandom_range(99) < pa);
      settle();
      n = 0;
      for (int k = 0; k < AW; k++) n += int'(allocReq[k]);
      expReady = (n <= q.size());
      checkVal("rnd_free", freeCnt, q.size());
      checkVal("rnd_used", usedCnt, DEPTH - q.size());
      checkVal("rnd_ready", allocReady, expReady);
      if (expReady) begin
        for (int k = 0; k < AW; k++) begin
          if (allocReq[k]) begin
            v = q.pop_front();
            checkVal("rnd_idx", laneIdx(k), v);
            used.push_back(v);
          end
        end
      end
      foreach (pend[p]) q.push_back(pend[p]);
      $display("txn rnd %0d req=%b fv=%b free=%0d ready=%0d", cyc, allocReq, freeValid, freeCnt, allocReady);
      tick();
    end
    allocReq  = '0;
    freeValid = '0;
    settle();
    checkVal("rnd_end_free", freeCnt, q.size());

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
